// File: rtl/vliw_regfile.sv
// vliw_regfile: shared integer register file for the STARBUG VLIW core.
// Every lane reads two operands combinationally and owns one write port.
// When several lanes write the same register in one cycle, the highest
// lane wins, because it is last in program order. Such conflicts are
// flagged for one cycle and counted, with the count saturating.
// A register written in cycle N reads back its new value before cycle N
// ends, so Decode sees Writeback of the same cycle.
//
// Build macro VLIW_REGFILE_BYPASS_EN:
//   defined   - the array updates on the rising edge and each read port
//               bypasses from the resolved write data;
//   undefined - the array updates on the falling edge with no bypass
//               muxes, so second half-cycle reads already see new data.
// Values seen at every rising edge are the same in both builds.
module vliw_regfile #(
    parameter int XLEN        = 32,
    parameter int NLANES      = 4,
    parameter int E_SUPPORTED = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NLANES-1:0]      we3,
    input  logic [NLANES*5-1:0]    a1,
    input  logic [NLANES*5-1:0]    a2,
    input  logic [NLANES*5-1:0]    a3,
    input  logic [NLANES*XLEN-1:0] wd3,
    output logic [NLANES*XLEN-1:0] rd1,
    output logic [NLANES*XLEN-1:0] rd2,
    output logic                   WriteConflict,
    output logic [15:0]            ConflictCount
);

    // x0 is hardwired, so only x1..x(NREGS-1) are stored
    localparam int NREGS = (E_SUPPORTED != 0) ? 16 : 32;

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic [XLEN-1:0] rd_src [1:NREGS-1];
    logic            conflict_any;
    logic            write_conflict_q;
    logic            write_conflict_d;
    logic [15:0]     conflict_count_q;
    logic [15:0]     conflict_count_d;

    // RV32E has only 16 registers, so address bit 4 is dropped there
    function automatic logic [4:0] eff_addr(input logic [4:0] addr);
        logic [4:0] res;
        res = addr;
        if (E_SUPPORTED != 0) begin
            res[4] = 1'b0;
        end
        return res;
    endfunction

    // Resolve writes per register: ascending lane scan, so the last lane to hit wins
    always_comb begin
        logic [NREGS-1:1] hit;
        hit          = '0;
        conflict_any = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int l = 0; l < NLANES; l++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (we3[l] && (eff_addr(a3[l*5 +: 5]) == 5'(r))) begin
                    if (hit[r]) begin
                        conflict_any = 1'b1;
                    end
                    hit[r]    = 1'b1;
                    regs_d[r] = wd3[l*XLEN +: XLEN];
                end
            end
        end
    end

    // Conflict flag follows this cycle; the counter adds one per conflicting cycle, stopping at all-ones
    always_comb begin
        write_conflict_d = conflict_any;
        conflict_count_d = conflict_count_q;
        if (conflict_any && (conflict_count_q != 16'hFFFF)) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    // Conflict status registers update on the rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_conflict_q <= 1'b0;
            conflict_count_q <= 16'd0;
        end else begin
            write_conflict_q <= write_conflict_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    // Register array: rising-edge write with bypass, or falling-edge write without
`ifdef VLIW_REGFILE_BYPASS_EN
    always_ff @(posedge clk or negedge reset) begin
`else
    always_ff @(negedge clk or negedge reset) begin
`endif
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

`ifdef VLIW_REGFILE_BYPASS_EN
    assign rd_src = regs_d;
`else
    assign rd_src = regs_q;
`endif

    // Read ports: address decode per lane, x0 falls through to zero
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int l = 0; l < NLANES; l++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (eff_addr(a1[l*5 +: 5]) == 5'(r)) begin
                    rd1[l*XLEN +: XLEN] = rd_src[r];
                end
                if (eff_addr(a2[l*5 +: 5]) == 5'(r)) begin
                    rd2[l*XLEN +: XLEN] = rd_src[r];
                end
            end
        end
    end

    assign WriteConflict = write_conflict_q;
    assign ConflictCount = conflict_count_q;

endmodule

// File: doc/vliw_regfile.md
# vliw_regfile

Shared integer register file for the STARBUG VLIW core. It sits directly upstream of the per-lane integer datapaths in Decode. Each lane sends its read addresses and its Writeback write port here and receives its two operands back. The block also resolves same-cycle multi-lane writes to one destination and counts those conflicts for debug.

## Interface
Parameters:
- `XLEN`, default 32: register width (32 or 64).
- `NLANES`, default 4: number of issue lanes; legal values 1–4.
- `E_SUPPORTED`, default 0: 1 selects RV32E, giving 16 architectural registers (x0–x15).

Ports (each port below is a packed array with one slice per lane; lane i uses slice i):
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `we3` input NLANES: per-lane write enable.
- `a1` input NLANES*5: per-lane source-1 address.
- `a2` input NLANES*5: per-lane source-2 address.
- `a3` input NLANES*5: per-lane destination address.
- `wd3` input NLANES*XLEN: per-lane write data.
- `rd1` output NLANES*XLEN: per-lane source-1 data.
- `rd2` output NLANES*XLEN: per-lane source-2 data.
- `WriteConflict` output 1: registered pulse; high for one cycle after any write conflict.
- `ConflictCount` output 16: saturating count of cycles that had a write conflict.

## Operation
- Storage:
  - 31 entries x1–x31, or 15 entries x1–x15 when `E_SUPPORTED`.
  - x0 is not stored and always reads 0.
  - Writes to x0 are discarded and never count as conflicts.
- E mode addressing: address bit 4 is ignored on reads and writes. Example: `a1`=17 reads x1.
- Reads: `rd1`/`rd2` for every lane are combinational functions of that lane's `a1`/`a2` and the current array contents.
- Write resolution, per destination register:
  - Effective lane set = lanes with `we3` high and a matching nonzero `a3`.
  - The highest-numbered lane in the set wins. Lane order equals program order within a bundle.
- Conflict detection:
  - A conflict is a cycle in which two or more lanes write the same nonzero register.
  - `WriteConflict` is registered at the rising edge that ends the conflicting cycle.
  - On that same edge `ConflictCount` increments by 1 and saturates at 16'hFFFF.
  - Multiple conflicting registers in one cycle still add only 1.
- Reset (`reset`=0, asynchronous):
  - All entries clear to 0; `WriteConflict`=0; `ConflictCount`=0.
  - Writes in flight are lost.
  - Deassertion is taken synchronously at the next rising edge; the first write can occur in that cycle.

## Timing
- Read latency: 0 cycles (combinational).
- Write-to-read visibility is architecturally fixed, with or without the configuration feature:
  - A read issued in the same cycle as a write to the same register returns the new `wd3` before the cycle ends.
  - This lets Decode in cycle N see the Writeback of cycle N without a forwarding path.
- Read from a register with a same-cycle conflicting write: returns the winning lane's data.
- No stall or flush inputs. Callers gate `we3`. Holding `we3` high with constant inputs rewrites the same value, which is harmless.
- `WriteConflict` and `ConflictCount`: 1-cycle latency; update on the rising edge only.

## Configuration
- `VLIW_REGFILE_BYPASS_EN`:
  - Defined: the array is written on the rising edge of `clk`. Each read port has a combinational bypass comparing its address against all lanes' `a3`/`we3`; a hit selects the winning lane's `wd3`. This gives the visibility above with single-edge timing.
  - Undefined: the array is written on the falling edge of `clk` with no bypass muxes. Reads in the second half-cycle see the new value.
- Observable values at each rising edge are identical in both builds.

## Test plan
- Reset: hold `reset`=0 mid-run after writing x5=32'hDEAD → `rd1`(x5)=0 immediately; `ConflictCount`=0; `WriteConflict`=0.
- Same-cycle read-after-write: lane 0 writes x7=32'h1234 while lane 3 `a2`=7 → lane 3 `rd2`=32'h1234 at the end of that cycle, in both builds.
- Conflict priority: lanes 1 and 2 both write x9 (32'h11, 32'h22) → x9=32'h22 next cycle; `WriteConflict`=1 for one cycle; `ConflictCount`=1.
- x0 handling: all four lanes write x0 with different data → `rd1`(x0)=0; no conflict; count unchanged.
- Saturation: 65536 consecutive conflicting cycles → `ConflictCount`=16'hFFFF and holds there.
- E mode (`E_SUPPORTED`=1): write x3=32'hAB through `a3`=19 → `a1`=3 and `a1`=19 both read 32'hAB.
